uart_tx: RTL and testbench
==========================

# uart_tx

UART serializer that sits directly downstream of the ALU-result transmit buffer. It takes the buffered byte and "data ready" flag, and shifts the byte onto the serial line as a start/data/stop frame, LSB first. It returns a one-cycle completion pulse that clears the buffer's full flag. Bit timing is driven by the shared oversampling baud tick, which is also used by the receiver.

## Interface
- DBIT, 8: data bits per frame.
- OVERSAMPLE, 16: baud ticks per start/data/parity bit.
- SB_TICK, 16: baud ticks in the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2).

- i_clk  in  1  system clock.
- i_reset  in  1  reset, synchronous, active-high.
- i_tick  in  1  baud tick, one-cycle pulse at OVERSAMPLE × baud rate.
- i_tx_start  in  1  data-ready level from the transmit buffer (its full flag).
- i_data  in  DBIT  byte to send; sampled only at frame start.
- o_tx  out  1  serial line, registered, idle high.
- o_tx_done  out  1  one-cycle pulse at end of frame; wired to the buffer's transmission-done input.
- o_busy  out  1  high whenever state ≠ IDLE.

## Operation
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- Registers:
  - state
  - tick counter s, width clog2(max(OVERSAMPLE, SB_TICK))
  - bit counter n, width clog2(DBIT)
  - shift register b[DBIT-1:0]
  - tx_reg
  - done_reg
- IDLE:
  - tx_reg=1.
  - If i_tx_start=1: load b←i_data, s←0, then go to START.
  - i_tick is ignored.
- START:
  - tx_reg=0.
  - On i_tick: if s==OVERSAMPLE-1, then s←0, n←0, go to DATA. Otherwise s←s+1.
- DATA:
  - tx_reg=b[0].
  - On i_tick with s==OVERSAMPLE-1: s←0, b←b>>1.
  - Then, if n==DBIT-1, go to PARITY (macro on) or STOP. Otherwise n←n+1.
- PARITY: tx_reg=parity bit. On i_tick with s==OVERSAMPLE-1: s←0, go to STOP.
- STOP:
  - tx_reg=1.
  - On i_tick with s==SB_TICK-1: go to IDLE and set done_reg=1 for exactly one clock.
- No tick-driven transition in any state occurs without i_tick.
- i_tx_start is ignored outside IDLE.
- i_data changes mid-frame have no effect.
- i_tx_start still high on the first IDLE cycle after done does not start a new frame. The buffer's flag clears on the same edge that done is seen.
  - Proven handshake: done at cycle N → flag low at N+1. The new frame starts no earlier than N+2.
- Reset mid-frame: at the next edge, state=IDLE, o_tx=1, o_tx_done=0, o_busy=0, and all counters are 0. The partial frame is abandoned.

## Timing
- Reset values: o_tx=1, o_tx_done=0, o_busy=0.
- i_tx_start sampled high in IDLE at edge k: o_tx=0 and o_busy=1 from edge k.
- Frame length: (1+DBIT+P)×OVERSAMPLE+SB_TICK ticks, where P=1 with parity, else 0.
- o_tx_done is high for the single cycle after the last stop tick. o_busy=0 in that same cycle.
- o_tx is driven only from a flop, so it is glitch-free.

## Configuration
- UART_TX_PARITY_EN defined:
  - PARITY state is compiled in.
  - Transmits even parity: XOR of the i_data captured at start, held in a 1-bit register.
- UART_TX_PARITY_EN undefined:
  - No PARITY state and no parity register.
  - DATA goes directly to STOP.

## Structure
- Shared package uart_pkg holds:
  - state encoding localparams (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4)
  - default DBIT/OVERSAMPLE/SB_TICK values, also used by the receiver
- No sub-module is needed. The baud tick comes from the existing shared baud generator, outside this block.

## Test plan
- Reset, then idle with ticks running → o_tx=1, o_busy=0, no o_tx_done.
- i_data=0x55, start pulse, tick every 4 clocks → line holds each bit for 16 ticks: 0,1,0,1,0,1,0,1,0,1. o_tx_done fires once after 160 ticks.
- Back-to-back with the buffer model, bytes 0xA3 then 0x0F → two complete frames. The second start bit begins at least 2 clocks after the first done pulse.
- Change i_data to 0xFF during DATA of a 0x00 frame → all eight data bits stay 0.
- Assert i_reset at tick 70 of a frame → o_tx=1 and o_busy=0 at the next edge. A new start afterwards produces a clean full frame.
- With UART_TX_PARITY_EN: 0x07 → parity bit 1; 0x03 → parity bit 0. Frame is 176 ticks.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame defaults and the transmitter state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Optional parity state is enabled by UART_TX_PARITY_EN.
package uart_pkg;

    // Frame defaults, shared with the receiver
    localparam int UART_DBIT       = 8;
    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_SB_TICK    = 16;

    // State encoding, kept stable so the receiver and debug tooling agree
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = IDLE,
        S_START  = START,
        S_DATA   = DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY = PARITY,
`endif
        S_STOP   = STOP
    } tx_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART serializer: start/data(LSB first)/[even parity]/stop frame paced by the oversampling baud tick.
// Latency: line drops low on the same edge i_tx_start is taken; o_tx_done pulses one cycle after the last stop tick.
// Backpressure: i_tx_start is ignored while busy and on the done cycle; UART_TX_PARITY_EN adds the parity bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT       = UART_DBIT,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int SB_TICK    = UART_SB_TICK
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_tick,
    input  logic            i_tx_start,
    input  logic [DBIT-1:0] i_data,
    output logic            o_tx,
    output logic            o_tx_done,
    output logic            o_busy
);

    localparam int SW = $clog2(max_int(OVERSAMPLE, SB_TICK));
    localparam int NW = $clog2(DBIT);

    localparam logic [SW-1:0] S_ONE   = SW'(1);
    localparam logic [SW-1:0] OS_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] SB_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] N_ONE   = NW'(1);
    localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);

    tx_state_t       state, state_next;
    logic [SW-1:0]   s, s_next;
    logic [NW-1:0]   n, n_next;
    logic [DBIT-1:0] b, b_next;
    logic            tx_reg, tx_next;
    logic            done_reg, done_next;

`ifdef UART_TX_PARITY_EN
    logic            par_reg;
`endif

    // Next-state logic: tick-paced walk through the frame
    always_comb begin
        state_next = state;
        s_next     = s;
        n_next     = n;
        b_next     = b;
        done_next  = 1'b0;
        case (state)
            S_IDLE: begin
                // done_reg blocks a restart while the buffer's flag is still clearing
                if (i_tx_start && !done_reg) begin
                    b_next     = i_data;
                    s_next     = '0;
                    state_next = S_START;
                end
            end
            S_START: begin
                if (i_tick) begin
                    if (s == OS_LAST) begin
                        s_next     = '0;
                        n_next     = '0;
                        state_next = S_DATA;
                    end else begin
                        s_next = s + S_ONE;
                    end
                end
            end
            S_DATA: begin
                if (i_tick) begin
                    if (s == OS_LAST) begin
                        s_next = '0;
                        b_next = b >> 1;
                        if (n == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                            state_next = S_PARITY;
`else
                            state_next = S_STOP;
`endif
                        end else begin
                            n_next = n + N_ONE;
                        end
                    end else begin
                        s_next = s + S_ONE;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (i_tick) begin
                    if (s == OS_LAST) begin
                        s_next     = '0;
                        state_next = S_STOP;
                    end else begin
                        s_next = s + S_ONE;
                    end
                end
            end
`endif
            S_STOP: begin
                if (i_tick) begin
                    if (s == SB_LAST) begin
                        s_next     = '0;
                        state_next = S_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        s_next = s + S_ONE;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Line value for the state being entered, so the flop tracks state with no lag
    always_comb begin
        tx_next = 1'b1;
        case (state_next)
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = b_next[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_next = par_reg;
`endif
            default:  tx_next = 1'b1;
        endcase
    end

    // Frame state registers; reset abandons any partial frame
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= S_IDLE;
            s        <= '0;
            n        <= '0;
            b        <= '0;
            tx_reg   <= 1'b1;
            done_reg <= 1'b0;
        end else begin
            state    <= state_next;
            s        <= s_next;
            n        <= n_next;
            b        <= b_next;
            tx_reg   <= tx_next;
            done_reg <= done_next;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Even parity of the byte captured at frame start
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            par_reg <= 1'b0;
        end else if (state == S_IDLE && i_tx_start && !done_reg) begin
            par_reg <= ^i_data;
        end
    end
`endif

    assign o_tx      = tx_reg;
    assign o_tx_done = done_reg;
    assign o_busy    = (state != S_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: drivers push expected frames, a monitor decodes the line per tick.
// Latency: checks start on the take edge and done one cycle after the last stop tick.
// Backpressure: models the transmit buffer's full flag for back-to-back frames.
module tb_uart_tx;
    import uart_pkg::*;

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FRAME = (1 + 8 + P) * 16 + 16;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_tick;
    logic       i_tx_start;
    logic [7:0] i_data;
    logic       o_tx;
    logic       o_tx_done;
    logic       o_busy;

    uart_tx dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_tick     (i_tick),
        .i_tx_start (i_tx_start),
        .i_data     (i_data),
        .o_tx       (o_tx),
        .o_tx_done  (o_tx_done),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } exp_t;

    exp_t   sb_q[$];
    int     errors = 0;
    int     checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Baud tick: one-cycle pulse every 4 clocks while enabled
    bit     tick_en = 1'b0;
    int     tdiv = 0;
    longint cyc = 0;
    initial begin
        i_tick = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            cyc++;
            tdiv = (tdiv + 1) % 4;
            i_tick = tick_en && (tdiv == 0);
        end
    end

    function automatic logic exp_bit(input exp_t e, input int c);
        int k;
        k = c / 16;
        if (k == 0) return 1'b0;
        if (k <= 8) return e.data[k-1];
        if (P == 1 && k == 9) return e.par;
        return 1'b1;
    endfunction

    // Monitor: decode each frame tick by tick against the scoreboard head
    bit     in_frame = 1'b0;
    int     cnt = 0;
    int     mism = 0;
    int     first_bad = -1;
    exp_t   cur;
    bit     prev_done = 1'b0;
    longint last_done_cyc = -1;
    int     done_cnt = 0;
    initial begin
        cur = '{8'h00, 1'b0};
        forever begin
            @(negedge i_clk);
            if (prev_done) chk("done_width", o_tx_done, 0);
            prev_done = o_tx_done;
            if (o_tx_done) begin
                done_cnt++;
                last_done_cyc = cyc;
                chk("done_busy_low", o_busy, 0);
                chk("done_in_frame", in_frame, 1);
                if (in_frame) begin
                    if (sb_q.size() > 0) void'(sb_q.pop_front());
                    chk($sformatf("frame_len_%02h", cur.data), cnt, FRAME);
                    chk($sformatf("line_bits_%02h_firstbad%0d", cur.data, first_bad), mism, 0);
                    in_frame = 1'b0;
                end
            end else if (in_frame && !o_busy) begin
                // frame abandoned by reset
                if (sb_q.size() > 0) void'(sb_q.pop_front());
                in_frame = 1'b0;
            end
            if (!in_frame && o_busy) begin
                in_frame  = 1'b1;
                cnt       = 0;
                mism      = 0;
                first_bad = -1;
                chk("start_low", o_tx, 0);
                if (last_done_cyc >= 0) chk("start_gap_ge2", ((cyc - last_done_cyc) >= 2), 1);
                chk("sb_nonempty", (sb_q.size() > 0), 1);
                if (sb_q.size() > 0) cur = sb_q[0];
            end
            if (in_frame && i_tick) begin
                if (o_tx !== exp_bit(cur, cnt)) begin
                    mism++;
                    if (first_bad < 0) first_bad = cnt;
                end
                cnt++;
            end
        end
    end

    task automatic send_pulse(input logic [7:0] d, input logic par);
        @(posedge i_clk); #1;
        i_data = d;
        sb_q.push_back('{d, par});
        i_tx_start = 1'b1;
        @(posedge i_clk); #1;
        i_tx_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge i_clk);
            if (o_tx_done) begin
                got = 1'b1;
                break;
            end
        end
        chk({"done_seen_", name}, got, 1);
    endtask

    // Buffer model: flag set on load, cleared on the edge after done is seen
    task automatic buf_send(input logic [7:0] d, input logic par, input string name);
        @(posedge i_clk); #1;
        i_data = d;
        sb_q.push_back('{d, par});
        i_tx_start = 1'b1;
        wait_done(name);
        @(posedge i_clk); #1;
        i_tx_start = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        i_reset    = 1'b1;
        i_tx_start = 1'b0;
        i_data     = 8'h00;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("reset_tx", o_tx, 1);
        chk("reset_busy", o_busy, 0);
        chk("reset_done", o_tx_done, 0);
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        tick_en = 1'b1;

        // idle with ticks running
        for (int r = 0; r < 3; r++) begin
            repeat (20) @(negedge i_clk);
            chk("idle_tx", o_tx, 1);
            chk("idle_busy", o_busy, 0);
            chk("idle_done", o_tx_done, 0);
        end

        // alternating pattern
        send_pulse(8'h55, 1'b0);
        wait_done("55");

        // back-to-back through the buffer model
        buf_send(8'hA3, 1'b0, "A3");
        buf_send(8'h0F, 1'b0, "0F");

        // data changes mid-frame are ignored
        send_pulse(8'h00, 1'b0);
        repeat (160) @(posedge i_clk);
        #1 i_data = 8'hFF;
        wait_done("00");
        repeat (10) @(posedge i_clk);

        // reset at tick 70 of a frame
        send_pulse(8'h5A, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge i_clk);
            if (in_frame && cnt >= 70) begin
                hit = 1'b1;
                break;
            end
        end
        chk("reached_tick70", hit, 1);
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        chk("midrst_tx", o_tx, 1);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_done", o_tx_done, 0);
        i_reset = 1'b0;
        repeat (5) @(posedge i_clk);
        send_pulse(8'hC6, 1'b0);
        wait_done("C6");

        // parity patterns (odd and even weight)
        send_pulse(8'h07, 1'b1);
        wait_done("07");
        send_pulse(8'h03, 1'b0);
        wait_done("03");

        repeat (20) @(negedge i_clk);
        chk("queue_empty", sb_q.size(), 0);
        chk("done_total", done_cnt, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
